// File: rtl/swd_seq_pkg.sv
// SWD special-sequence generator: shared op codes, states and defaults.
// Optional abort input is enabled with SWD_SEQ_ABORT_EN.
package swd_seq_pkg;

  localparam logic [1:0] OP_LINE_RESET  = 2'd0;
  localparam logic [1:0] OP_IDLE        = 2'd1;
  localparam logic [1:0] OP_JTAG_TO_SWD = 2'd2;
  localparam logic [1:0] OP_RAW         = 2'd3;

  localparam logic [15:0] SWITCH_CODE_DEF = 16'hE79E;
  localparam int          MIN_RESET_DEF   = 50;
  localparam int          IDLE_TAIL_DEF   = 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ONES  = 3'd1,
    S_CODE  = 3'd2,
    S_ONES2 = 3'd3,
    S_ZEROS = 3'd4,
    S_RAW   = 3'd5,
    S_DONE  = 3'd6
  } state_t;

endpackage

// File: rtl/swd_seq_gen_shifter.sv
// LSB-first loadable shift register with a phase down-counter.
// last_o marks the final bit of the currently loaded phase.
module swd_bit_shifter #(
  parameter int W  = 32,
  parameter int CW = 9
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          load_i,
  input  logic          shift_i,
  input  logic [W-1:0]  data_i,
  input  logic [CW-1:0] len_i,
  output logic          bit_o,
  output logic          last_o
);

  logic [W-1:0]  data_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else if (load_i) begin
      data_q <= data_i;
      cnt_q  <= len_i;
    end else if (shift_i) begin
      data_q <= data_q >> 1;
      if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
    end
  end

  assign bit_o  = data_q[0];
  assign last_o = (cnt_q == CW'(1));

endmodule

// File: rtl/swd_seq_gen.sv
// SWD line-reset / idle / JTAG-to-SWD / raw bit sequencer.
// Define SWD_SEQ_ABORT_EN to add the abort input.
module swd_seq_gen
  import swd_seq_pkg::*;
#(
  parameter int          CNT_W       = 8,
  parameter int          RAW_W       = 32,
  parameter int          MIN_RESET   = MIN_RESET_DEF,
  parameter int          IDLE_TAIL   = IDLE_TAIL_DEF,
  parameter logic [15:0] SWITCH_CODE = SWITCH_CODE_DEF
) (
  input  logic             sck,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_len,
  input  logic [RAW_W-1:0] cmd_raw,
`ifdef SWD_SEQ_ABORT_EN
  input  logic             abort,
`endif
  output logic             swdio_out,
  output logic             swdio_oe,
  output logic             swclk_en,
  output logic             busy,
  output logic             done
);

  localparam int CW = CNT_W + 1;
  localparam logic [CW-1:0] MIN_C  = CW'(MIN_RESET);
  localparam logic [CW-1:0] RAW_C  = CW'(RAW_W);
  localparam logic [CW-1:0] TAIL_C = CW'(IDLE_TAIL);
  localparam logic [CW-1:0] CODE_C = CW'(16);
  localparam bit HAS_TAIL = (IDLE_TAIL > 0);

  state_t         state_q, state_d;
  logic [1:0]     op_q, op_d;
  logic           load, shift;
  logic [RAW_W-1:0] ld_data;
  logic [CW-1:0]  ld_len, len_x;
  logic           sh_bit, sh_last;
  logic           emit;

  assign len_x = {1'b0, cmd_len};

  swd_bit_shifter #(
    .W  (RAW_W),
    .CW (CW)
  ) u_shift (
    .clk_i   (sck),
    .rst_ni  (rst_n),
    .load_i  (load),
    .shift_i (shift),
    .data_i  (ld_data),
    .len_i   (ld_len),
    .bit_o   (sh_bit),
    .last_o  (sh_last)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    load    = 1'b0;
    shift   = 1'b0;
    ld_data = '0;
    ld_len  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d = cmd_op;
          load = 1'b1;
          unique case (cmd_op)
            OP_LINE_RESET: begin
              state_d = S_ONES;
              ld_len  = (len_x > MIN_C) ? len_x : MIN_C;
            end
            OP_IDLE: begin
              state_d = (cmd_len == '0) ? S_DONE : S_ZEROS;
              ld_len  = len_x;
            end
            OP_JTAG_TO_SWD: begin
              state_d = S_ONES;
              ld_len  = MIN_C;
            end
            default: begin
              state_d = (cmd_len == '0) ? S_DONE : S_RAW;
              ld_data = cmd_raw;
              ld_len  = (len_x < RAW_C) ? len_x : RAW_C;
            end
          endcase
        end
      end
      S_ONES: begin
        shift = 1'b1;
        if (sh_last) begin
          load = 1'b1;
          if (op_q == OP_JTAG_TO_SWD) begin
            state_d = S_CODE;
            ld_data = RAW_W'(SWITCH_CODE);
            ld_len  = CODE_C;
          end else begin
            state_d = HAS_TAIL ? S_ZEROS : S_DONE;
            ld_len  = TAIL_C;
          end
        end
      end
      S_CODE: begin
        shift = 1'b1;
        if (sh_last) begin
          load    = 1'b1;
          state_d = S_ONES2;
          ld_len  = MIN_C;
        end
      end
      S_ONES2: begin
        shift = 1'b1;
        if (sh_last) begin
          load    = 1'b1;
          state_d = HAS_TAIL ? S_ZEROS : S_DONE;
          ld_len  = TAIL_C;
        end
      end
      S_ZEROS, S_RAW: begin
        shift = 1'b1;
        if (sh_last) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
`ifdef SWD_SEQ_ABORT_EN
    // Drop the rest of the sequence; S_DONE already ends it.
    if (abort && state_q != S_IDLE && state_q != S_DONE) begin
      state_d = S_DONE;
      load    = 1'b0;
      shift   = 1'b0;
    end
`endif
  end

  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_LINE_RESET;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  assign emit = (state_q == S_ONES) || (state_q == S_CODE) ||
                (state_q == S_ONES2) || (state_q == S_ZEROS) ||
                (state_q == S_RAW);

  assign cmd_ready = (state_q == S_IDLE);
  assign swclk_en  = emit;
  assign swdio_oe  = emit;
  assign busy      = emit;
  assign done      = (state_q == S_DONE);
  assign swdio_out = (state_q == S_ONES) || (state_q == S_ONES2) ||
                     (((state_q == S_CODE) || (state_q == S_RAW)) && sh_bit);

endmodule

// File: tb/tb_swd_seq_gen.sv
// Randomised and directed bench for swd_seq_gen.
// Build with SWD_SEQ_ABORT_EN to also exercise abort.
module tb_swd_seq_gen;

  logic        sck = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'd0;
  logic [7:0]  cmd_len = 8'd0;
  logic [31:0] cmd_raw = 32'd0;
  logic        cmd_ready, swdio_out, swdio_oe;
  logic        swclk_en, busy, done;
`ifdef SWD_SEQ_ABORT_EN
  logic        abort = 1'b0;
`endif

  int total = 0;
  int bad = 0;
  bit exp_q[$];
  bit cap[$];

  always #5 sck = ~sck;

  swd_seq_gen dut (
    .sck       (sck),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .cmd_raw   (cmd_raw),
`ifdef SWD_SEQ_ABORT_EN
    .abort     (abort),
`endif
    .swdio_out (swdio_out),
    .swdio_oe  (swdio_oe),
    .swclk_en  (swclk_en),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected bit stream straight from the sequence definitions.
  function automatic void model(input logic [1:0] op,
                                input int len,
                                input logic [31:0] raw);
    logic [15:0] code;
    int n;
    code = 16'hE79E;
    exp_q.delete();
    case (op)
      2'd0: begin
        n = (len > 50) ? len : 50;
        repeat (n) exp_q.push_back(1'b1);
        repeat (2) exp_q.push_back(1'b0);
      end
      2'd1: repeat (len) exp_q.push_back(1'b0);
      2'd2: begin
        repeat (50) exp_q.push_back(1'b1);
        for (int i = 0; i < 16; i++) exp_q.push_back(code[i]);
        repeat (50) exp_q.push_back(1'b1);
        repeat (2) exp_q.push_back(1'b0);
      end
      default: begin
        n = (len < 32) ? len : 32;
        for (int i = 0; i < n; i++) exp_q.push_back(raw[i]);
      end
    endcase
  endfunction

  task automatic start_cmd(input logic [1:0] op,
                           input logic [7:0] len,
                           input logic [31:0] raw);
    @(negedge sck);
    check("ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = len;
    cmd_raw   = raw;
    @(posedge sck);
    #1;
    cmd_valid = 1'b0;
    cmd_raw   = $urandom;
    cmd_len   = 8'($urandom);
  endtask

  task automatic run_cmd(input logic [1:0] op,
                         input logic [7:0] len,
                         input logic [31:0] raw,
                         input string tag);
    int lat, oe_bad, busy_bad, gap, mism;
    bit got_done;
    logic [2:0] at_done;
    model(op, int'(len), raw);
    cap.delete();
    lat = 0; oe_bad = 0; busy_bad = 0; gap = 0;
    got_done = 0; at_done = 3'b000;
    start_cmd(op, len, raw);
    for (int c = 0; c < 600 && !got_done; c++) begin
      @(negedge sck);
      lat++;
      if (done) begin
        got_done = 1;
        at_done = {swclk_en, swdio_oe, busy};
      end else if (swclk_en) begin
        cap.push_back(swdio_out);
        if (!swdio_oe) oe_bad++;
        if (!busy) busy_bad++;
      end else begin
        gap++;
      end
    end
    check({tag, ".done_seen"}, 32'(got_done), 1);
    if (!got_done) return;
    check({tag, ".latency"}, lat, exp_q.size() + 1);
    check({tag, ".nbits"}, cap.size(), exp_q.size());
    mism = 0;
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++)
      if (cap[i] != exp_q[i]) mism++;
    check({tag, ".bit_errs"}, mism, 0);
    check({tag, ".oe_low"}, oe_bad, 0);
    check({tag, ".busy_low"}, busy_bad, 0);
    check({tag, ".gaps"}, gap, 0);
    check({tag, ".done_outs"}, 32'(at_done), 0);
    @(negedge sck);
    check({tag, ".done_1cyc"}, done, 0);
    check({tag, ".ready_after"}, cmd_ready, 1);
    check({tag, ".oe_after"}, swdio_oe, 0);
  endtask

  initial begin
    logic [15:0] w16;
    logic [7:0]  w8;
    logic [1:0]  rop;
    logic [7:0]  rlen;
    #1;
    check("rst.out", swdio_out, 0);
    check("rst.oe", swdio_oe, 0);
    check("rst.clk", swclk_en, 0);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.ready", cmd_ready, 1);
    #11 rst_n = 1'b1;

    run_cmd(2'd0, 8'd10, 32'd0, "lr10");
    run_cmd(2'd0, 8'd64, 32'd0, "lr64");
    run_cmd(2'd1, 8'd50, 32'd0, "idle50");
    run_cmd(2'd2, 8'd7, 32'd0, "j2s");
    w16 = '0;
    if (cap.size() >= 66)
      for (int i = 0; i < 16; i++) w16[i] = cap[50 + i];
    check("j2s.code_word", w16, 16'hE79E);
    run_cmd(2'd3, 8'd8, 32'hA5, "raw8");
    w8 = '0;
    if (cap.size() >= 8)
      for (int i = 0; i < 8; i++) w8[i] = cap[i];
    check("raw8.byte", w8, 8'hA5);
    run_cmd(2'd3, 8'd40, 32'hC3A5_5A3C, "raw40");
    run_cmd(2'd1, 8'd0, 32'd0, "idle0");
    run_cmd(2'd3, 8'd0, 32'hFFFF_FFFF, "raw0");
    run_cmd(2'd3, 8'd1, 32'h1, "raw1");

    // Reset in the middle of a line reset.
    start_cmd(2'd0, 8'd10, 32'd0);
    repeat (20) @(negedge sck);
    check("mid.clk_on", swclk_en, 1);
    #1 rst_n = 1'b0;
    #1;
    check("mid.out", swdio_out, 0);
    check("mid.oe", swdio_oe, 0);
    check("mid.clk", swclk_en, 0);
    check("mid.busy", busy, 0);
    check("mid.done", done, 0);
    #1 rst_n = 1'b1;
    @(negedge sck);
    check("mid.ready", cmd_ready, 1);
    check("mid.no_tail", swclk_en, 0);
    run_cmd(2'd0, 8'd51, 32'd0, "after_rst");

`ifdef SWD_SEQ_ABORT_EN
    start_cmd(2'd2, 8'd0, 32'd0);
    repeat (30) @(negedge sck);
    check("abort.bit30", swclk_en, 1);
    abort = 1'b1;
    @(negedge sck);
    abort = 1'b0;
    check("abort.clk", swclk_en, 0);
    check("abort.oe", swdio_oe, 0);
    check("abort.done", done, 1);
    @(negedge sck);
    check("abort.idle_clk", swclk_en, 0);
    check("abort.ready", cmd_ready, 1);
    abort = 1'b1;
    @(negedge sck);
    check("abort.idle_ign", done, 0);
    abort = 1'b0;
    run_cmd(2'd0, 8'd0, 32'd0, "post_abort");
`endif

    for (int k = 0; k < 20; k++) begin
      rop  = 2'($urandom_range(0, 3));
      rlen = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3))
                                         : 8'($urandom);
      run_cmd(rop, rlen, $urandom, $sformatf("rnd%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
